// File: rtl/ts_capture_mem_pkg.sv
// Shared record layout and FSM encoding for the timestamp capture buffer.
package ts_capture_pkg;

    localparam int REC_WIDTH = 128;
    localparam int TS_LSB    = 64;
    localparam int SEQ_LSB   = 32;
    localparam int DATA_LSB  = 0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAPTURE,
        S_FULL
    } state_e;

endpackage

// File: rtl/ts_capture_mem_if.sv
// Event-in / wide-read-out bundle between the register bank and the capture buffer.
interface ts_capture_mem_if
    import ts_capture_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int EVT_WIDTH  = 32
);

    logic                  enable_i;
    logic                  event_i;
    logic [EVT_WIDTH-1:0]  evt_data_i;
    logic [ADDR_WIDTH-1:0] ts_addr_i;
    logic [REC_WIDTH-1:0]  ts_data_o;
    logic [ADDR_WIDTH:0]   count_o;
    logic                  full_o;
    logic                  overflow_o;

    modport master (
        output enable_i, event_i, evt_data_i, ts_addr_i,
        input  ts_data_o, count_o, full_o, overflow_o
    );

    modport slave (
        input  enable_i, event_i, evt_data_i, ts_addr_i,
        output ts_data_o, count_o, full_o, overflow_o
    );

endinterface

// File: rtl/ts_capture_mem_ram.sv
// Simple dual-port RAM: one write port, one registered read-first read port.
module ts_capture_ram #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 128
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    always_ff @(posedge clk_i) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // Non-blocking read of the array returns pre-write contents on collision.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_rdata <= '0;
        else       r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/ts_capture_mem.sv
// Timestamped event capture buffer with a wide 1-cycle read port.
// Define TS_CAPTURE_WRAP_EN to overwrite the oldest entry instead of stopping when full.
module ts_capture_mem
    import ts_capture_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int EVT_WIDTH  = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    ts_capture_mem_if.slave  bus
);

    localparam int                  DEPTH  = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] L_FULL = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] L_LAST = (ADDR_WIDTH+1)'(DEPTH - 1);

    state_e                 r_state;
    state_e                 w_next;
    logic                   r_enable_d;
    logic [63:0]            r_ts;
    logic [31:0]            r_seq;
    logic [ADDR_WIDTH-1:0]  r_wr_ptr;
    logic [ADDR_WIDTH:0]    r_count;
    logic                   r_ovf;
    logic                   r_stg_vld;
    logic [REC_WIDTH-1:0]   r_stg_rec;
    logic                   w_rearm;
    logic                   w_accept;
    logic                   w_drop;
    logic                   w_we;
    logic [31:0]            w_data;
    logic [REC_WIDTH-1:0]   w_rec;

    assign w_rearm = bus.enable_i & ~r_enable_d;
    assign w_data  = 32'(bus.evt_data_i);
    assign w_we    = r_stg_vld & ~w_rearm;

    always_comb begin
        w_rec                    = '0;
        w_rec[TS_LSB   +: 64]    = r_ts;
        w_rec[SEQ_LSB  +: 32]    = r_seq;
        w_rec[DATA_LSB +: 32]    = w_data;
    end

`ifndef TS_CAPTURE_WRAP_EN
    // Count the staged record too so back-to-back events cannot over-fill.
    logic [ADDR_WIDTH:0] w_fill;
    assign w_fill = r_count + (ADDR_WIDTH+1)'(r_stg_vld);
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_drop   = 1'b0;
        if (!bus.enable_i) begin
            w_next = S_IDLE;
        end else if (w_rearm) begin
            w_next = S_CAPTURE;
        end else begin
            unique case (r_state)
                S_CAPTURE: begin
                    if (bus.event_i) begin
                        w_accept = 1'b1;
`ifndef TS_CAPTURE_WRAP_EN
                        if (w_fill == L_LAST) w_next = S_FULL;
`endif
                    end
                end
                S_FULL: begin
                    if (bus.event_i) w_drop = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_enable_d <= 1'b0;
            r_ts       <= '0;
            r_seq      <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_ovf      <= 1'b0;
            r_stg_vld  <= 1'b0;
            r_stg_rec  <= '0;
        end else begin
            r_enable_d <= bus.enable_i;
            r_ts       <= r_ts + 64'd1;
            if (w_rearm) begin
                r_seq     <= '0;
                r_wr_ptr  <= '0;
                r_count   <= '0;
                r_ovf     <= 1'b0;
                r_stg_vld <= 1'b0;
            end else begin
                r_stg_vld <= w_accept;
                if (w_accept) r_stg_rec <= w_rec;
                if (w_accept || w_drop) r_seq <= r_seq + 32'd1;
                if (w_drop) r_ovf <= 1'b1;
                if (r_stg_vld) begin
                    r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
                    if (r_count == L_FULL) r_ovf   <= 1'b1;
                    else                   r_count <= r_count + (ADDR_WIDTH+1)'(1);
                end
            end
        end
    end

    ts_capture_ram #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (REC_WIDTH)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (r_stg_rec),
        .i_raddr (bus.ts_addr_i),
        .o_rdata (bus.ts_data_o)
    );

    assign bus.count_o    = r_count;
    assign bus.full_o     = (r_count == L_FULL);
    assign bus.overflow_o = r_ovf;

endmodule

// File: tb/tb_ts_capture_mem.sv
// Directed checks of capture, fill/overflow, rearm, read-first and async reset.
module tb_ts_capture_mem;
    import ts_capture_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ts_capture_mem_if #(.ADDR_WIDTH(5), .EVT_WIDTH(32)) bus ();

    ts_capture_mem #(.ADDR_WIDTH(5), .EVT_WIDTH(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    // Reference cycle counter: edges seen since reset release.
    logic [63:0] ecnt;
    always @(posedge clk or posedge rst) begin
        if (rst) ecnt <= '0;
        else     ecnt <= ecnt + 64'd1;
    end

    int nvec  = 0;
    int nfail = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rec(input logic [63:0] t, input logic [31:0] s,
                                         input logic [31:0] d);
        return {t, s, d};
    endfunction

    task automatic rd(input int a, output logic [127:0] d);
        bus.ts_addr_i = 5'(a);
        tick();
        d = bus.ts_data_o;
    endtask

    task automatic ev(input logic [31:0] d, output logic [63:0] t);
        bus.event_i    = 1'b1;
        bus.evt_data_i = d;
        t              = ecnt;
        tick();
        bus.event_i    = 1'b0;
    endtask

    logic [127:0] d0, d1, dx;
    logic [63:0]  t0, t1, tc, tx, tdum, tdiff;
    logic [63:0]  tf [33];

    initial begin
        bus.enable_i   = 1'b0;
        bus.event_i    = 1'b0;
        bus.evt_data_i = '0;
        bus.ts_addr_i  = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", 128'(bus.count_o), 128'd0);
        chk("rst_full", 128'(bus.full_o), 128'd0);
        chk("rst_ovf", 128'(bus.overflow_o), 128'd0);
        chk("rst_data", bus.ts_data_o, 128'd0);
        rst = 1'b0;

        tick();
        bus.enable_i = 1'b1;
        tick();

        ev(32'hCAFE_0001, t0);
        tick();
        chk("ev1_count", 128'(bus.count_o), 128'd1);
        rd(0, d0);
        chk("ev1_word", d0, rec(t0, 32'd0, 32'hCAFE_0001));

        ev(32'hBEEF_0002, t1);
        tick();
        chk("ev2_count", 128'(bus.count_o), 128'd2);
        rd(1, d1);
        rd(0, d0);
        chk("ev2_word", d1, rec(t0 + 64'd3, 32'd1, 32'hBEEF_0002));
        tdiff = d1[127:64] - d0[127:64];
        chk("ev2_tsdiff", 128'(tdiff), 128'd3);

        bus.enable_i = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) ev(32'hDEAD_0000 + 32'(i), tdum);
        tick();
        chk("dis_count", 128'(bus.count_o), 128'd2);
        chk("dis_ovf", 128'(bus.overflow_o), 128'd0);
        rd(0, dx);
        chk("dis_ram0", dx, rec(t0, 32'd0, 32'hCAFE_0001));
        rd(1, dx);
        chk("dis_ram1", dx, rec(t0 + 64'd3, 32'd1, 32'hBEEF_0002));

        bus.enable_i   = 1'b1;
        bus.event_i    = 1'b1;
        bus.evt_data_i = 32'h0BAD_0BAD;
        tick();
        bus.event_i = 1'b0;
        tick();
        tick();
        chk("rearm_count", 128'(bus.count_o), 128'd0);
        chk("rearm_ovf", 128'(bus.overflow_o), 128'd0);
        rd(0, dx);
        chk("rearm_ram0", dx, rec(t0, 32'd0, 32'hCAFE_0001));

        for (int i = 0; i < 33; i++) ev(32'hA000_0000 + 32'(i), tf[i]);
        tick();
        tick();
        chk("fill_count", 128'(bus.count_o), 128'd32);
        chk("fill_full", 128'(bus.full_o), 128'd1);
        chk("fill_ovf", 128'(bus.overflow_o), 128'd1);
        rd(0, dx);
`ifdef TS_CAPTURE_WRAP_EN
        chk("fill_ram0", dx, rec(tf[32], 32'd32, 32'hA000_0020));
`else
        chk("fill_ram0", dx, rec(tf[0], 32'd0, 32'hA000_0000));
`endif
        rd(1, dx);
        chk("fill_ram1", dx, rec(tf[1], 32'd1, 32'hA000_0001));
        rd(31, dx);
        chk("fill_ram31", dx, rec(tf[31], 32'd31, 32'hA000_001F));

        bus.enable_i = 1'b0;
        tick();
        bus.enable_i = 1'b1;
        tick();
        chk("rearm2_count", 128'(bus.count_o), 128'd0);
        chk("rearm2_full", 128'(bus.full_o), 128'd0);
        chk("rearm2_ovf", 128'(bus.overflow_o), 128'd0);

        ev(32'h5000_0000, tdum);
        ev(32'h5000_0001, tdum);
        ev(32'h7777_0002, tc);
        bus.ts_addr_i = 5'd2;
        tick();
        chk("rfirst_old", bus.ts_data_o, rec(tf[2], 32'd2, 32'hA000_0002));
        tick();
        chk("rfirst_new", bus.ts_data_o, rec(tc, 32'd2, 32'h7777_0002));
        chk("rfirst_count", 128'(bus.count_o), 128'd3);

        ev(32'h9999_0003, tx);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_count", 128'(bus.count_o), 128'd0);
        chk("arst_data", bus.ts_data_o, 128'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        tick();
        rd(3, dx);
        chk("arst_ram3", dx, rec(tf[3], 32'd3, 32'hA000_0003));
        chk("arst_count2", 128'(bus.count_o), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
